fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of an 8-bit FIFO between N_REQ requesters in the FIFO's write-clock domain. Each grant is packet-locked: a requester keeps ownership until it writes a beat flagged `last`. The arbiter drives the FIFO's `wr`/`data_in` and honours its `full` flag, so no beat is ever written into a full FIFO.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 42 ++++
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-port arbiter:
//   - arb_state_e : arbiter states (IDLE = no grant held, OWN = packet-locked grant)
//   - DATA_W_DEF  : default beat width, matching the FIFO word width
//   - owner_w()   : width of a requester index (clog2, never below 1 bit)
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // A 2-requester arbiter still needs one index bit, hence the floor at 1.
  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Returns the first set bit of i_req found
// by searching upward from i_start with wrap-around.
// Ports:
//   i_req   in  N_REQ  request vector
//   i_start in  IDX_W  index searched first (must be < N_REQ)
//   o_valid out 1      at least one request is set
//   o_idx   out IDX_W  winning index (0 when o_valid is low)
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = owner_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; that is what keeps this block from inferring latches.
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    // Scan from the farthest candidate back to i_start: the nearest hit is
    // written last and therefore wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_pos = IDX_W'((int'(i_start) + k) % N_REQ);
      if (i_req[w_pos]) begin
        o_valid = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Packet-locked round-robin arbiter sharing one FIFO write port among N_REQ
// requesters. A requester keeps the grant until a beat flagged `last` is
// accepted; no beat is ever written while `full` is high.
// Optional feature macro: FIFO_ARB_BURST_LIMIT_EN -- caps each grant at
// MAX_BURST accepted beats, after which the grant is released as if `last`
// had been seen. Without the macro, release happens only on `last`.
// Ports:
//   wr_clk   in  1             write-domain clock
//   reset    in  1             asynchronous active-high reset
//   req      in  N_REQ         requester i has a valid beat
//   last     in  N_REQ         beat from requester i ends its packet
//   req_data in  N_REQ*DATA_W  flattened beats, slice i = [i*DATA_W +: DATA_W]
//   full     in  1             FIFO full flag
//   gnt      out N_REQ         registered one-hot grant (or zero)
//   wr       out 1             FIFO write enable
//   data_out out DATA_W        beat to FIFO data_in
//   busy     out 1             a grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic                    wr_clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        last,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    full,
  output logic [N_REQ-1:0]        gnt,
  output logic                    wr,
  output logic [DATA_W-1:0]       data_out,
  output logic                    busy
);

  localparam int            OW       = owner_w(N_REQ);
  localparam logic [OW-1:0] LAST_IDX = OW'(N_REQ - 1);

  arb_state_e       r_state;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_rr_last;
  logic [N_REQ-1:0] r_gnt;

  logic             w_own;
  logic             w_accept;
  logic             w_release;
  logic             w_grant;
  logic             w_burst_hit;
  logic             w_pick_valid;
  logic [OW-1:0]    w_pick_idx;
  logic [OW-1:0]    w_base;
  logic [OW-1:0]    w_start;
  logic [DATA_W-1:0] w_data;

  assign w_own    = (r_state == OWN);
  // full gates the write in the same cycle; there is no registered lag.
  assign w_accept = w_own & req[r_owner] & ~full;
  assign w_release = w_accept & (last[r_owner] | w_burst_hit);

  // Mux the owner's slice out of the flattened beat bus.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == OW'(i)) begin
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // One picker serves both cases: in IDLE it searches after rr_last, in the
  // release cycle after the current owner, which makes the releasing owner
  // the lowest-priority candidate.
  assign w_base  = w_own ? r_owner : r_rr_last;
  assign w_start = (w_base == LAST_IDX) ? '0 : w_base + 1'b1;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (OW)
  ) u_rr_pick (
    .i_req   (req),
    .i_start (w_start),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // A new grant is issued from IDLE, or back-to-back in a release cycle.
  assign w_grant = (~w_own | w_release) & w_pick_valid;

`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] r_beat_cnt;

  // Counter holds beats already accepted under this grant, so the cap is hit
  // while accepting beat number MAX_BURST.
  assign w_burst_hit = w_accept & (r_beat_cnt == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      r_beat_cnt <= '0;
    end else if (w_grant) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end
`else
  logic w_unused_burst;

  assign w_unused_burst = (MAX_BURST > 0);
  assign w_burst_hit    = 1'b0;
`endif

  always_ff @(posedge wr_clk or posedge reset) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_rr_last <= LAST_IDX;
      r_gnt     <= '0;
    end else begin
      if (w_release) begin
        r_rr_last <= r_owner;
      end
      if (w_grant) begin
        r_state <= OWN;
        r_owner <= w_pick_idx;
        r_gnt   <= N_REQ'(1) << w_pick_idx;
      end else if (w_release) begin
        r_state <= IDLE;
        r_gnt   <= '0;
      end
    end
  end

  // Outputs derive from r_state, so an asynchronous reset drops wr and busy
  // immediately, not at the next edge.
  assign gnt      = r_gnt;
  assign busy     = w_own;
  assign wr       = w_accept;
  assign data_out = w_own ? w_data : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (N_REQ=4, DATA_W=8, MAX_BURST=2).
// A cycle-level reference model (owner index, round-robin pointer, beat count)
// predicts gnt/wr/data_out/busy every cycle; directed scenarios additionally
// check the order of beats written to the FIFO. Builds with or without
// FIFO_ARB_BURST_LIMIT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 2;
`ifdef FIFO_ARB_BURST_LIMIT_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*DW-1:0] req_data;
  logic            full;
  logic [N-1:0]    gnt;
  logic            wr;
  logic [DW-1:0]   data_out;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .wr_clk   (clk),
    .reset    (rst),
    .req      (req),
    .last     (last),
    .req_data (req_data),
    .full     (full),
    .gnt      (gnt),
    .wr       (wr),
    .data_out (data_out),
    .busy     (busy)
  );

  int    checks = 0;
  int    errors = 0;
  string tag    = "init";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h, expected %0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_owner;  // -1 when no grant is held
  int m_rr;
  int m_cnt;

  function automatic int choose(input int rq, input int after);
    for (int k = 1; k <= N; k++) begin
      if (((rq >> ((after + k) % N)) & 1) == 1) return (after + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_rr    = N - 1;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    int rq;
    int ls;
    rq = int'(req);
    ls = int'(last);
    if (m_owner < 0) begin
      m_owner = choose(rq, m_rr);
      m_cnt   = 0;
    end else if (((rq >> m_owner) & 1) == 1 && !full) begin
      m_cnt++;
      if (((ls >> m_owner) & 1) == 1 || (BURST_ON && m_cnt == MB)) begin
        m_rr    = m_owner;
        m_owner = choose(rq, m_owner);
        m_cnt   = 0;
      end
    end
  endtask

  // ---------------- cycle driver ----------------
  logic [N-1:0]  s_gnt;
  logic          s_wr;
  logic [DW-1:0] s_data;
  logic [DW-1:0] wlog[$];

  task automatic set_slice(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // Called just after a negedge with inputs applied; checks, then clocks.
  task automatic tick();
    int rq, eg, ew, ed, eb;
    #2;
    rq = int'(req);
    eg = 0; ew = 0; ed = 0; eb = 0;
    if (m_owner >= 0) begin
      eg = 1 << m_owner;
      eb = 1;
      ed = int'((req_data >> (m_owner * DW)) & 32'hFF);
      ew = (((rq >> m_owner) & 1) == 1 && !full) ? 1 : 0;
    end
    check("gnt",      32'(gnt),      32'(eg));
    check("wr",       32'(wr),       32'(ew));
    check("data_out", 32'(data_out), 32'(ed));
    check("busy",     32'(busy),     32'(eb));
    s_gnt  = gnt;
    s_wr   = wr;
    s_data = data_out;
    if (wr) wlog.push_back(data_out);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    last     = '0;
    req_data = '0;
    full     = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt",  32'(gnt),      32'h0);
    check("rst_wr",   32'(wr),       32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_busy", 32'(busy),     32'h0);
    rst   = 1'b0;
    s_gnt = '0;
    s_wr  = 1'b0;
    wlog.delete();
  endtask

  task automatic check_log(input logic [DW-1:0] exp[$]);
    check("log_len", 32'(wlog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wlog.size(); i++) begin
      check($sformatf("log[%0d]", i), 32'(wlog[i]), 32'(exp[i]));
    end
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic          full;
    logic [N-1:0]  gnt;
    logic          wr;
    logic [DW-1:0] data;
  } vec_t;

  vec_t          tbl[4];
  logic [DW-1:0] exp_q[$];
  logic [N-1:0]  hold;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '0; last = '0; req_data = '0; full = 1'b0;
    model_reset();

    // ---- 1: two single-beat requesters, table-driven ----
    tag = "rr_table";
    tbl[0] = '{4'b0110, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[1] = '{4'b0110, 1'b0, 4'b0010, 1'b1, 8'h11};
    tbl[2] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'h22};
    tbl[3] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 8'h22};
    do_reset();
    req_data = 32'h33221100;
    last     = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req  = tbl[i].req;
      full = tbl[i].full;
      tick();
      check($sformatf("tbl%0d_gnt", i),  32'(s_gnt),  32'(tbl[i].gnt));
      check($sformatf("tbl%0d_wr", i),   32'(s_wr),   32'(tbl[i].wr));
      check($sformatf("tbl%0d_data", i), 32'(s_data), 32'(tbl[i].data));
    end
    exp_q = '{8'h11, 8'h22};
    check_log(exp_q);

    // ---- 2: 3-beat packet, then immediate handover ----
    tag = "handover";
    do_reset();
    begin
      logic [DW-1:0] a[3];
      int idx0, done1, a2_cyc, b_cyc;
      a = '{8'hA0, 8'hA1, 8'hA2};
      idx0 = 0; done1 = 0; a2_cyc = -10; b_cyc = -20;
      set_slice(1, 8'hB0);
      for (int c = 0; c < 6; c++) begin
        req[0]  = (idx0 < 3);
        last[0] = (idx0 == 2);
        set_slice(0, a[(idx0 < 3) ? idx0 : 2]);
        req[1]  = (done1 == 0);
        last[1] = 1'b1;
        tick();
        if (s_wr && s_gnt == 4'b0001) begin
          if (idx0 == 2) a2_cyc = c;
          idx0++;
        end
        if (s_wr && s_gnt == 4'b0010) begin
          done1 = 1;
          b_cyc = c;
        end
      end
      check("gap", 32'(b_cyc - a2_cyc), 32'd1);
    end
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
    check_log(exp_q);

    // ---- 3: full for three cycles mid-packet ----
    tag = "full_stall";
    do_reset();
    begin
      int idx, stall_wr;
      idx = 0; stall_wr = 0;
      for (int c = 0; c < 9; c++) begin
        req[0]  = (idx < 4);
        last[0] = (idx == 3);
        set_slice(0, 8'(8'hC0 + idx));
        full    = (c >= 2 && c <= 4);
        tick();
        if (c >= 2 && c <= 4) begin
          stall_wr += int'(s_wr);
          check($sformatf("stall%0d_gnt", c), 32'(s_gnt), 32'h1);
        end
        if (c == 5) begin
          check("resume_wr",   32'(s_wr),   32'h1);
          check("resume_data", 32'(s_data), 32'hC1);
        end
        if (s_wr) idx++;
      end
      check("stall_writes", 32'(stall_wr), 32'd0);
    end
    exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    check_log(exp_q);

    // ---- 4: reset in the middle of a 5-beat packet ----
    tag = "mid_reset";
    do_reset();
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 3; c++) begin
        req[2]  = 1'b1;
        last[2] = 1'b0;
        set_slice(2, 8'(8'h50 + idx));
        tick();
        if (s_wr) idx++;
      end
      rst = 1'b1;
      #1;
      check("async_gnt",  32'(gnt),  32'h0);
      check("async_wr",   32'(wr),   32'h0);
      check("async_busy", 32'(busy), 32'h0);
      model_reset();
      @(negedge clk);
      rst  = 1'b0;
      req  = 4'b1001;
      last = 4'b1001;
      tick();
      tick();
      check("post_rst_gnt", 32'(s_gnt), 32'h1);
    end
    exp_q = '{8'h50, 8'h51, 8'h00};
    check_log(exp_q);

    // ---- 5: burst limit (expected order depends on the build) ----
    tag = "burst";
    do_reset();
    begin
      logic [DW-1:0] d[4];
      int idx2, done3;
      d = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
      idx2 = 0; done3 = 0;
      set_slice(3, 8'hE0);
      for (int c = 0; c < 10; c++) begin
        req[2]  = (idx2 < 4);
        last[2] = (idx2 == 3);
        set_slice(2, d[(idx2 < 4) ? idx2 : 3]);
        req[3]  = (done3 == 0);
        last[3] = 1'b1;
        tick();
        if (s_wr && s_gnt == 4'b0100) idx2++;
        if (s_wr && s_gnt == 4'b1000) done3 = 1;
      end
    end
    if (BURST_ON) exp_q = '{8'hD1, 8'hD2, 8'hE0, 8'hD3, 8'hD4};
    else          exp_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hE0};
    check_log(exp_q);

    // ---- 6: randomized traffic against the model ----
    tag = "random";
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      hold = req & s_gnt & {N{full}};
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          req[i]  = ($urandom_range(0, 3) != 0);
          last[i] = ($urandom_range(0, 2) == 0);
          set_slice(i, 8'($urandom));
        end
      end
      full = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
